tdm_demux: RTL

//  Time-division demultiplexer: receiving end of the serial TDM lane that the MUX2-based

---
 rtl/tdm_demux.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// TDM lane demultiplexer: steers serial words into NCH channel slots using a frame-sync marker
// and presents each completed frame in parallel. Optional macro: TDM_DEMUX_SYNC_ERR_EN.
module tdm_demux #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int CW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   in_sync,
  output logic                   in_ready,
  output logic [NCH*WIDTH-1:0]   frame_data,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   locked,
  output logic                   sync_err
);

  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t               state;
  logic [CW-1:0]        idx;
  logic [CW-1:0]        idx_step;
  logic [NCH*WIDTH-1:0] next_frame;
  logic                 in_lock;
  logic                 at_last;
  logic                 accept;
  logic                 complete;

  assign in_lock  = (state == LOCK);
  assign at_last  = (idx == LAST);
  // Only the completing word can stall, and only while the output bank is still occupied.
  assign in_ready = !(frame_valid && !frame_ready && in_lock && at_last);
  assign accept   = in_valid && in_ready;
  assign complete = accept && in_lock && !in_sync && at_last;

  generate
    if ((1 << CW) == NCH) begin : g_wrap
      assign idx_step = idx + CW'(1);
    end else begin : g_cmp
      assign idx_step = at_last ? '0 : idx + CW'(1);
    end
  endgenerate

  // Shadow slots 0..NCH-2; the last channel word goes straight into the output bank.
  genvar gi;
  generate
    for (gi = 0; gi < NCH - 1; gi++) begin : g_slot
      logic             wr;
      logic [WIDTH-1:0] slot;

      if (gi == 0) begin : g_first
        assign wr = accept && in_sync;
      end else begin : g_rest
        assign wr = accept && in_lock && !in_sync && (idx == CW'(gi));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot <= '0;
        end else if (wr) begin
          slot <= in_data;
        end
      end

      assign next_frame[gi*WIDTH +: WIDTH] = slot;
    end
  endgenerate

  assign next_frame[(NCH-1)*WIDTH +: WIDTH] = in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      idx    <= '0;
      locked <= 1'b0;
    end else if (accept) begin
      if (in_sync) begin
        state  <= LOCK;
        locked <= 1'b1;
        idx    <= CW'(1);
      end else if (in_lock) begin
        if (idx == '0) begin
          state  <= HUNT;
          locked <= 1'b0;
        end else begin
          idx <= idx_step;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
    end else if (complete) begin
      frame_data  <= next_frame;
      frame_valid <= 1'b1;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

`ifdef TDM_DEMUX_SYNC_ERR_EN
  logic err_event;

  // Sync mid-frame (resync) or a missing sync at frame start while locked.
  assign err_event = accept && in_lock && (in_sync ? (idx != '0) : (idx == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= err_event;
    end
  end
`else
  assign sync_err = 1'b0;
`endif

endmodule
